// File: rtl/window_avg_pkg.sv
// Shared types and helpers for the window-average sink stage.
package window_avg_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    // Window length for a log2 size n.
    function automatic int unsigned win_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Half-window offset that turns the truncating shift into round-half-up.
    function automatic int unsigned round_offset(input int unsigned n);
        return (n == 0) ? 32'd0 : (32'd1 << (n - 32'd1));
    endfunction

endpackage

// File: rtl/window_average_sink_if.sv
// Valid/ready output bus carrying window averages.
interface window_average_sink_if #(
    parameter int unsigned DW = 8
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo2_sync.sv
// Two-entry synchronous FIFO; push while full is accepted only alongside a pop.
module fifo2_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & (count != 2'd0);
    assign push_ok = push & ((count != 2'd2) | pop_ok);

    // Storage and occupancy update; head is always the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/window_average_sink.sv
// Converts free-running window sums to rounded averages behind a 2-deep buffer.
module window_average_sink
    import window_avg_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DW-1:0]         in_sum,
    window_average_sink_if.master out,
    output logic [DW-1:0]         peak,
    output logic                  overrun,
    output logic [CW-1:0]         overrun_cnt
);
    localparam int unsigned WIN = win_len(N);
    localparam int unsigned RND = round_offset(N);

    state_e        state;
    state_e        state_nxt;
    logic [N-1:0]  warm_cnt;
    logic [N-1:0]  warm_cnt_nxt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop;
    logic [DW:0]   sum_ext;
    logic [DW-1:0] avg;

    // State and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state    <= WARMUP;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    // Warm-up waits one full window before any sum is meaningful.
    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        push         = 1'b0;
        unique case (state)
            WARMUP: begin
                warm_cnt_nxt = warm_cnt + N'(1);
                if (warm_cnt == N'(WIN - 1)) begin
                    state_nxt    = RUN;
                    warm_cnt_nxt = '0;
                end
            end
            RUN:     push = 1'b1;
            default: state_nxt = WARMUP;
        endcase
    end

    // One extra bit keeps the rounding offset from wrapping a full-scale sum.
    assign sum_ext = {1'b0, in_sum} + (DW+1)'(RND);
    assign avg     = DW'(sum_ext >> N);

    assign pop  = out.out_valid & out.out_ready;
    assign drop = push & fifo_full & ~pop;

    fifo2_sync #(.WIDTH(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (avg),
        .dout  (out.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out.out_valid = ~fifo_empty;

    // Peak hold sees every computed average, dropped or not.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            peak <= '0;
        end else if (state == RUN && avg > peak) begin
            peak <= avg;
        end
    end

    // Sticky overrun flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (overrun_cnt != {CW{1'b1}}) overrun_cnt <= overrun_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_window_average_sink.sv
// Self-checking bench for window_average_sink: directed tables plus random stream vs queue model.
module tb_window_average_sink;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int WIN = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_sum;
    logic [DW-1:0] peak;
    logic          overrun;
    logic [CW-1:0] overrun_cnt;

    window_average_sink_if #(.DW(DW)) bus ();

    window_average_sink #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_sum      (in_sum),
        .out         (bus),
        .peak        (peak),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered averages, cycles since restart, summary stats.
    int m_q[$];
    int m_cyc;
    int m_peak;
    int m_ovr;
    int m_cnt;

    typedef struct {
        int sum;
        int exp_avg;
    } vec_t;

    function automatic int ref_avg(input int s);
        return (s + WIN / 2) / WIN;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit f, input int s, input bit rdy);
        int  a;
        int  tmp;
        bit  run;
        if (!r || f) begin
            m_q.delete();
            m_cyc  = 0;
            m_peak = 0;
            m_ovr  = 0;
            m_cnt  = 0;
        end else begin
            run = (m_cyc >= WIN);
            if (rdy && m_q.size() > 0) tmp = m_q.pop_front();
            if (m_cyc < WIN) m_cyc++;
            if (run) begin
                a = ref_avg(s);
                if (a > m_peak) m_peak = a;
                if (m_q.size() < 2) begin
                    m_q.push_back(a);
                end else begin
                    m_ovr = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("valid", int'(bus.out_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("data", int'(bus.out_data), m_q[0]);
        chk("peak", int'(peak), m_peak);
        chk("overrun", int'(overrun), m_ovr);
        chk("overrun_cnt", int'(overrun_cnt), m_cnt);
    endtask

    task automatic step(input bit r, input bit f, input int s, input bit rdy);
        rst_n         = r;
        flush         = f;
        in_sum        = DW'(s);
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(r, f, s, rdy);
        #1;
        check_model();
    endtask

    // Restart via flush or reset with a full buffer, then time the warm-up.
    task automatic restart_check(input bit use_rst);
        step(1'b1, 1'b0, 40, 1'b0);
        step(1'b1, 1'b0, 40, 1'b0);
        step(1'b1, 1'b0, 40, 1'b0);
        chk("pre_restart_valid", int'(bus.out_valid), 1);
        if (use_rst) step(1'b0, 1'b0, 200, 1'b1);
        else         step(1'b1, 1'b1, 200, 1'b1);
        chk("restart_valid", int'(bus.out_valid), 0);
        chk("restart_peak", int'(peak), 0);
        chk("restart_ovr", int'(overrun), 0);
        chk("restart_cnt", int'(overrun_cnt), 0);
        for (int k = 1; k <= WIN + 1; k++) begin
            step(1'b1, 1'b0, 200, 1'b1);
            chk("restart_warm", int'(bus.out_valid), int'(k == WIN + 1));
        end
        chk("restart_first", int'(bus.out_data), 13);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{255, 16};
        tbl[1] = '{24, 2};
        tbl[2] = '{23, 1};
        tbl[3] = '{0, 0};
        tbl[4] = '{8, 1};
        tbl[5] = '{7, 0};
        tbl[6] = '{127, 8};
        tbl[7] = '{248, 16};

        // Reset
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_peak", int'(peak), 0);

        // Warm-up: first average visible in cycle 17
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 'h7F, 1'b1);
            chk("warm_valid", int'(bus.out_valid), int'(k >= 17));
            if (k == 17) begin
                chk("warm_data", int'(bus.out_data), 8);
                chk("warm_peak", int'(peak), 8);
            end
        end

        // Rounding table, each result one cycle after its sum
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, tbl[i].sum, 1'b1);
            chk("round", int'(bus.out_data), tbl[i].exp_avg);
        end

        // Backpressure from an empty buffer right after warm-up
        step(1'b1, 1'b1, 0, 1'b0);
        for (int k = 0; k < WIN; k++) step(1'b1, 1'b0, 0, 1'b0);
        chk("bp_empty", int'(bus.out_valid), 0);
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 16 * k, 1'b0);
        chk("bp_ovr", int'(overrun), 1);
        chk("bp_cnt", int'(overrun_cnt), 3);
        chk("bp_head", int'(bus.out_data), 1);
        step(1'b1, 1'b0, 96, 1'b1);
        chk("bp_second", int'(bus.out_data), 2);
        step(1'b1, 1'b0, 112, 1'b1);
        chk("bp_new", int'(bus.out_data), 6);

        // Full with simultaneous pop: no drops, one average per cycle
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 16 * k, 1'b1);
            chk("fullpop_valid", int'(bus.out_valid), 1);
            chk("fullpop_cnt", int'(overrun_cnt), 3);
        end

        restart_check(1'b0);
        restart_check(1'b1);

        // Peak includes dropped averages, then counter saturation
        step(1'b1, 1'b1, 0, 1'b0);
        for (int k = 0; k < WIN; k++) step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 16, 1'b0);
        chk("peak_a", int'(peak), 1);
        step(1'b1, 1'b0, 255, 1'b0);
        chk("peak_b", int'(peak), 16);
        step(1'b1, 1'b0, 32, 1'b0);
        chk("peak_c", int'(peak), 16);
        chk("peak_drop", int'(overrun_cnt), 1);
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, $urandom_range(0, 255), 1'b0);
        chk("sat_cnt", int'(overrun_cnt), 255);
        chk("sat_ovr", int'(overrun), 1);

        // Random stream with occasional restarts
        for (int k = 0; k < 3000; k++) begin
            step(bit'($urandom_range(0, 199) != 0), bit'($urandom_range(0, 99) == 0),
                 int'($urandom_range(0, 255)), bit'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
